param_eeprom_ctrl: RTL and testbench

PARAM_EEPROM_CTRL -- requirements
Module: param_eeprom_ctrl

---
 rtl/param_eeprom_ctrl.sv | 174 +++++++++++++++++
 tb/tb_param_eeprom_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_eeprom_ctrl.sv
// Parameter editor with EEPROM persistence: boots by reading three bytes,
// lets the user edit them with keys, and writes a snapshot back on save.
module param_eeprom_ctrl #(
    parameter int MAX_VAL    = 99,
    parameter int DEF_VAL    = 0,
    parameter int BOOT_DELAY = 5_000_000,
    parameter int TIMEOUT    = 50_000_000
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic        key_sel,
    input  logic        key_inc,
    input  logic        key_dec,
    input  logic        key_save,
    input  logic [23:0] read_3bytes,
    input  logic        write_3bytes_done,
    input  logic        read_3bytes_done,
    output logic [23:0] write_3bytes,
    output logic        write_3bytes_trig,
    output logic        read_3bytes_trig,
    output logic [7:0]  param0,
    output logic [7:0]  param1,
    output logic [7:0]  param2,
    output logic [1:0]  sel_idx,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        BOOT_WAIT,
        RD_REQ,
        RD_WAIT,
        IDLE,
        WR_REQ,
        WR_WAIT
    } state_t;

    // One shared counter serves both the boot delay and the transfer timeout.
    localparam int               CNT_MAX   = (BOOT_DELAY > TIMEOUT) ? BOOT_DELAY : TIMEOUT;
    localparam int               CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_DELAY - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       MAX_B     = 8'(MAX_VAL);
    localparam logic [7:0]       DEF_B     = 8'(DEF_VAL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       param_q [3];
    logic [7:0]       param_d [3];
    logic [1:0]       sel_idx_q, sel_idx_d;
    logic [23:0]      write_3bytes_q, write_3bytes_d;
    logic             write_trig_q, write_trig_d;
    logic             read_trig_q, read_trig_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    function automatic logic [7:0] sanitize(input logic [7:0] b);
        return (b > MAX_B) ? DEF_B : b;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d        = state_q;
        cnt_d          = cnt_q;
        param_d        = param_q;
        sel_idx_d      = sel_idx_q;
        write_3bytes_d = write_3bytes_q;
        err_d          = err_q;

        case (state_q)
            BOOT_WAIT: begin
                if (cnt_q == BOOT_LAST) begin
                    cnt_d   = '0;
                    state_d = RD_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RD_REQ: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // A done pulse on the final timeout cycle still counts as success.
                if (read_3bytes_done) begin
                    param_d[0] = sanitize(read_3bytes[23:16]);
                    param_d[1] = sanitize(read_3bytes[15:8]);
                    param_d[2] = sanitize(read_3bytes[7:0]);
                    state_d    = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    param_d = '{DEF_B, DEF_B, DEF_B};
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE: begin
                if (key_save) begin
                    write_3bytes_d = {param_q[0], param_q[1], param_q[2]};
                    state_d        = WR_REQ;
                end else if (key_sel) begin
                    sel_idx_d = (sel_idx_q == 2'd2) ? 2'd0 : sel_idx_q + 2'd1;
                end else if (key_inc || key_dec) begin
                    for (int i = 0; i < 3; i++) begin
                        if (sel_idx_q == 2'(i)) begin
                            if (key_inc)
                                param_d[i] = (param_q[i] == MAX_B) ? 8'd0 : param_q[i] + 8'd1;
                            else
                                param_d[i] = (param_q[i] == 8'd0) ? MAX_B : param_q[i] - 8'd1;
                        end
                    end
                end
            end
            WR_REQ: begin
                cnt_d   = '0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (write_3bytes_done) begin
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = BOOT_WAIT;
        endcase

        // Request states last exactly one cycle, so the trigger is a single pulse.
        read_trig_d  = (state_d == RD_REQ);
        write_trig_d = (state_d == WR_REQ);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge sclk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!nrst) begin
            state_q        <= BOOT_WAIT;
            cnt_q          <= '0;
            param_q        <= '{DEF_B, DEF_B, DEF_B};
            sel_idx_q      <= 2'd0;
            write_3bytes_q <= 24'd0;
            write_trig_q   <= 1'b0;
            read_trig_q    <= 1'b0;
            busy_q         <= 1'b1;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            param_q        <= param_d;
            sel_idx_q      <= sel_idx_d;
            write_3bytes_q <= write_3bytes_d;
            write_trig_q   <= write_trig_d;
            read_trig_q    <= read_trig_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign write_3bytes      = write_3bytes_q;
    assign write_3bytes_trig = write_trig_q;
    assign read_3bytes_trig  = read_trig_q;
    assign param0            = param_q[0];
    assign param1            = param_q[1];
    assign param2            = param_q[2];
    assign sel_idx           = sel_idx_q;
    assign busy              = busy_q;
    assign err               = err_q;

endmodule

// File: tb/tb_param_eeprom_ctrl.sv
// Self-checking bench for param_eeprom_ctrl: boot load, editing, save,
// timeouts, key priority and mid-transfer reset.
module tb_param_eeprom_ctrl;

    localparam int MAX_VAL    = 99;
    localparam int DEF_VAL    = 0;
    localparam int BOOT_DELAY = 10;
    localparam int TIMEOUT    = 100;

    logic        sclk = 1'b0;
    logic        nrst = 1'b0;
    logic        key_sel = 1'b0, key_inc = 1'b0, key_dec = 1'b0, key_save = 1'b0;
    logic [23:0] read_3bytes = 24'd0;
    logic        write_3bytes_done = 1'b0, read_3bytes_done = 1'b0;
    logic [23:0] write_3bytes;
    logic        write_3bytes_trig, read_3bytes_trig;
    logic [7:0]  param0, param1, param2;
    logic [1:0]  sel_idx;
    logic        busy, err;

    param_eeprom_ctrl #(
        .MAX_VAL(MAX_VAL), .DEF_VAL(DEF_VAL), .BOOT_DELAY(BOOT_DELAY), .TIMEOUT(TIMEOUT)
    ) dut (
        .sclk(sclk), .nrst(nrst),
        .key_sel(key_sel), .key_inc(key_inc), .key_dec(key_dec), .key_save(key_save),
        .read_3bytes(read_3bytes),
        .write_3bytes_done(write_3bytes_done), .read_3bytes_done(read_3bytes_done),
        .write_3bytes(write_3bytes),
        .write_3bytes_trig(write_3bytes_trig), .read_3bytes_trig(read_3bytes_trig),
        .param0(param0), .param1(param1), .param2(param2),
        .sel_idx(sel_idx), .busy(busy), .err(err)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [23:0] params;
        logic [1:0]  sel;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    logic [23:0] wr_q[$];
    logic [7:0]  m_p [3];
    logic [1:0]  m_sel;
    bit          m_idle;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic model_reset();
        m_p    = '{8'(DEF_VAL), 8'(DEF_VAL), 8'(DEF_VAL)};
        m_sel  = 2'd0;
        m_idle = 1'b0;
    endtask

    // Waits (bounded) for the read trigger, starting from cycle count n0.
    task automatic wait_read_trig(input int n0);
        int n = n0;
        while (!read_3bytes_trig && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n !== BOOT_DELAY) begin
            errors++;
            $display("FAIL boot_delay: read_trig after %0d cycles, expected %0d", n, BOOT_DELAY);
        end
    endtask

    // Completes the read: checks the one-cycle trigger, returns data, checks the load.
    task automatic finish_read(input logic [23:0] data, input logic [23:0] expect_p);
        tick();
        checks++;
        if (read_3bytes_trig !== 1'b0) begin
            errors++;
            $display("FAIL read_trig_width: got %b expected 0", read_3bytes_trig);
        end
        read_3bytes      = data;
        read_3bytes_done = 1'b1;
        tick();
        read_3bytes_done = 1'b0;
        checks++;
        if ({param0, param1, param2} !== expect_p) begin
            errors++;
            $display("FAIL load_params: got %h expected %h", {param0, param1, param2}, expect_p);
        end
        checks++;
        if ({busy, err} !== 2'b00) begin
            errors++;
            $display("FAIL load_status: busy/err got %b expected 00", {busy, err});
        end
        m_p    = '{expect_p[23:16], expect_p[15:8], expect_p[7:0]};
        m_sel  = 2'd0;
        m_idle = 1'b1;
    endtask

    task automatic boot(input logic [23:0] data, input logic [23:0] expect_p);
        nrst = 1'b0;
        tick();
        model_reset();
        nrst = 1'b1;
        wait_read_trig(0);
        finish_read(data, expect_p);
    endtask

    task automatic press_key(input logic s, input logic i, input logic d, input logic v);
        exp_t        e;
        logic [23:0] w;
        key_sel = s; key_inc = i; key_dec = d; key_save = v;
        if (m_idle) begin
            if (v) begin
                wr_q.push_back({m_p[0], m_p[1], m_p[2]});
                m_idle = 1'b0;
            end else if (s) begin
                m_sel = (m_sel == 2'd2) ? 2'd0 : m_sel + 2'd1;
            end else if (i) begin
                m_p[m_sel] = (m_p[m_sel] == 8'(MAX_VAL)) ? 8'd0 : m_p[m_sel] + 8'd1;
            end else if (d) begin
                m_p[m_sel] = (m_p[m_sel] == 8'd0) ? 8'(MAX_VAL) : m_p[m_sel] - 8'd1;
            end
        end
        exp_q.push_back('{params: {m_p[0], m_p[1], m_p[2]}, sel: m_sel});
        tick();
        key_sel = 1'b0; key_inc = 1'b0; key_dec = 1'b0; key_save = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({param0, param1, param2} !== e.params) begin
            errors++;
            $display("FAIL key_params: got %h expected %h", {param0, param1, param2}, e.params);
        end
        checks++;
        if (sel_idx !== e.sel) begin
            errors++;
            $display("FAIL key_sel_idx: got %0d expected %0d", sel_idx, e.sel);
        end
        if (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            checks++;
            if (write_3bytes_trig !== 1'b1 || write_3bytes !== w) begin
                errors++;
                $display("FAIL save: trig=%b data=%h expected trig=1 data=%h",
                         write_3bytes_trig, write_3bytes, w);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({param0, param1, param2, sel_idx, write_3bytes, write_3bytes_trig,
             read_3bytes_trig, busy, err} !== {24'd0, 2'd0, 24'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s: params=%h sel=%0d wr=%h wtrig=%b rtrig=%b busy=%b err=%b expected 000000/0/000000/0/0/1/0",
                     tag, {param0, param1, param2}, sel_idx, write_3bytes,
                     write_3bytes_trig, read_3bytes_trig, busy, err);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset_state");
    endtask

    task automatic test_boot_load();
        boot(24'h17_38_27, {8'd23, 8'd56, 8'd39});
    endtask

    task automatic test_invalid_load();
        boot(24'hC8_05_FF, {8'd0, 8'd5, 8'd0});
    endtask

    task automatic test_edit_wrap();
        press_key(0, 0, 1, 0);   // 0 -> 99
        press_key(0, 1, 0, 0);   // 99 -> 0
        press_key(0, 0, 1, 0);   // 0 -> 99
        read_3bytes      = 24'h11_11_11;
        read_3bytes_done = 1'b1;
        write_3bytes_done = 1'b1;
        tick();
        read_3bytes_done = 1'b0;
        write_3bytes_done = 1'b0;
        checks++;
        if ({param0, param1, param2, busy} !== {8'd99, 8'd5, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL idle_done_ignored: got %h busy=%b expected 630500 busy=0",
                     {param0, param1, param2}, busy);
        end
        press_key(1, 0, 0, 0);
        press_key(1, 0, 0, 0);
        press_key(1, 0, 0, 0);
        press_key(1, 0, 0, 0);   // sel 1
        press_key(0, 1, 1, 0);   // inc beats dec: 5 -> 6
        press_key(1, 1, 1, 0);   // sel beats inc: sel 2
        press_key(0, 0, 1, 0);   // 0 -> 99
        press_key(1, 0, 0, 0);   // back to 0
    endtask

    task automatic test_save();
        boot(24'h01_02_03, {8'd1, 8'd2, 8'd3});
        press_key(0, 0, 0, 1);
        tick();
        checks++;
        if ({write_3bytes_trig, busy} !== 2'b01) begin
            errors++;
            $display("FAIL write_trig_width: trig/busy got %b expected 01", {write_3bytes_trig, busy});
        end
        press_key(0, 1, 0, 0);   // ignored in WR_WAIT
        write_3bytes_done = 1'b1;
        tick();
        write_3bytes_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL save_done_idle: busy got %b expected 0", busy);
        end
        m_idle = 1'b1;
        press_key(0, 1, 0, 0);   // 1 -> 2
        checks++;
        if (write_3bytes !== 24'h01_02_03) begin
            errors++;
            $display("FAIL snapshot_stable: got %h expected 010203", write_3bytes);
        end
    endtask

    task automatic test_wr_timeout();
        press_key(0, 0, 0, 1);   // snapshot 020203
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL wr_timeout_early: busy/err got %b expected 10", {busy, err});
        end
        tick();
        checks++;
        if ({busy, err, param0, param1, param2} !== {2'b01, 8'd2, 8'd2, 8'd3}) begin
            errors++;
            $display("FAIL wr_timeout: busy/err=%b params=%h expected 01 020203",
                     {busy, err}, {param0, param1, param2});
        end
        m_idle = 1'b1;
        press_key(0, 1, 0, 0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_rd_timeout();
        test_reset();
        nrst = 1'b1;
        wait_read_trig(0);
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL rd_timeout_early: busy/err got %b expected 10", {busy, err});
        end
        tick();
        checks++;
        if ({busy, err, param0, param1, param2} !== {2'b01, 24'd0}) begin
            errors++;
            $display("FAIL rd_timeout: busy/err=%b params=%h expected 01 000000",
                     {busy, err}, {param0, param1, param2});
        end
    endtask

    task automatic test_done_at_limit();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        wait_read_trig(0);
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        read_3bytes      = 24'h0A_0B_0C;
        read_3bytes_done = 1'b1;
        tick();
        read_3bytes_done = 1'b0;
        checks++;
        if ({busy, err, param0, param1, param2} !== {2'b00, 24'h0A_0B_0C}) begin
            errors++;
            $display("FAIL done_at_limit: busy/err=%b params=%h expected 00 0a0b0c",
                     {busy, err}, {param0, param1, param2});
        end
    endtask

    task automatic test_simultaneous();
        boot(24'h04_05_06, {8'd4, 8'd5, 8'd6});
        press_key(1, 0, 0, 0);   // sel 1
        press_key(0, 1, 0, 1);   // save wins, param1 stays 5
        tick();
        nrst = 1'b0;
        tick();
        check_reset_outputs("reset_mid_write");
        model_reset();
        nrst              = 1'b1;
        write_3bytes_done = 1'b1;
        read_3bytes_done  = 1'b1;
        tick();
        write_3bytes_done = 1'b0;
        read_3bytes_done  = 1'b0;
        wait_read_trig(1);
        finish_read(24'h07_08_09, {8'd7, 8'd8, 8'd9});
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_boot_load();
        test_invalid_load();
        test_edit_wrap();
        test_save();
        test_wr_timeout();
        test_rd_timeout();
        test_done_at_limit();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
